// File: rtl/pong_score_keeper.sv
// -----------------------------------------------------------------------------
// pong_score_keeper
//
// Match-level scoring and serve controller for the Pong game. Consumes the
// per-frame tick and goal pulses from the ball/paddle logic and returns serve
// and launch control to it. It keeps both scores in binary and in packed BCD
// for the display, runs the post-point pause, and detects the end of a match.
//
// Parameters:
//   WIN_SCORE   : points needed to win (1..99)
//   SERVE_DELAY : frame_tick pulses spent in the post-point pause (0..1023)
//
// Optional feature:
//   PONG_WIN_BY_TWO_EN : when defined, a win also needs a lead of at least
//                        two points (a score of 99 wins regardless).
//
// Ports:
//   CLOCK_50    in   system clock, all logic on its rising edge
//   reset       in   synchronous, active-high reset
//   frame_tick  in   one-cycle pulse per game update
//   goal_p1     in   one-cycle pulse, player 1 scored
//   goal_p2     in   one-cycle pulse, player 2 scored
//   serve_req   in   one-cycle pulse from the start button
//   ball_hold   out  hold the ball at centre with zero velocity
//   ball_launch out  one-cycle launch pulse
//   serve_dir   out  0 = launch toward player 2 (+x), 1 = toward player 1
//   p1_score    out  player 1 binary score (7 bits)
//   p2_score    out  player 2 binary score (7 bits)
//   p1_bcd      out  player 1 packed BCD score, tens in [7:4]
//   p2_bcd      out  player 2 packed BCD score, tens in [7:4]
//   game_over   out  match finished
//   winner      out  00 none, 01 player 1, 10 player 2
// -----------------------------------------------------------------------------
module pong_score_keeper #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       serve_req,
    output logic       ball_hold,
    output logic       ball_launch,
    output logic       serve_dir,
    output logic [6:0] p1_score,
    output logic [6:0] p2_score,
    output logic [7:0] p1_bcd,
    output logic [7:0] p2_bcd,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [6:0] WIN_L   = 7'(WIN_SCORE);
    localparam logic [9:0] DELAY_L = 10'(SERVE_DELAY);
    localparam logic [6:0] MAX_SCORE = 7'd99;

    typedef enum logic [1:0] {
        WAIT_SERVE  = 2'd0,
        PLAY        = 2'd1,
        POINT_DELAY = 2'd2,
        GAME_OVER   = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [9:0] cnt_reg, cnt_next;
    logic       serve_dir_reg, serve_dir_next;
    logic       launch_reg, launch_next;
    logic [1:0] winner_reg, winner_next;

    // Index 0 is player 1, index 1 is player 2.
    logic [6:0] score_reg [2];
    logic [6:0] score_next [2];
    logic [7:0] bcd_reg [2];
    logic [7:0] bcd_next [2];

    // Per-player incremented values and win test, computed in parallel so a
    // goal updates binary and BCD in the same cycle.
    logic [6:0] score_inc [2];
    logic [7:0] bcd_inc [2];
    logic       win_on_goal [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            logic [6:0] opp_score;
            logic       at_max;

            assign opp_score = score_reg[1 - gi];
            assign at_max    = (score_reg[gi] == MAX_SCORE);

            // Saturate at 99: both representations hold their value.
            assign score_inc[gi] = at_max ? score_reg[gi] : score_reg[gi] + 7'd1;

            always_comb begin
                bcd_inc[gi] = bcd_reg[gi];
                if (!at_max) begin
                    if (bcd_reg[gi][3:0] == 4'd9) begin
                        bcd_inc[gi][3:0] = 4'd0;
                        bcd_inc[gi][7:4] = bcd_reg[gi][7:4] + 4'd1;
                    end else begin
                        bcd_inc[gi][3:0] = bcd_reg[gi][3:0] + 4'd1;
                    end
                end
            end

`ifdef PONG_WIN_BY_TWO_EN
            // Lead compared in 8 bits so opp_score + 2 cannot wrap.
            assign win_on_goal[gi] = (score_inc[gi] >= WIN_L) &&
                                     (({1'b0, score_inc[gi]} >= ({1'b0, opp_score} + 8'd2)) ||
                                      (score_inc[gi] == MAX_SCORE));
`else
            assign win_on_goal[gi] = (score_inc[gi] >= WIN_L);
            logic unused_opp;
            assign unused_opp = ^opp_score;
`endif
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg     <= WAIT_SERVE;
            cnt_reg       <= '0;
            serve_dir_reg <= 1'b0;
            launch_reg    <= 1'b0;
            winner_reg    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                score_reg[i] <= '0;
                bcd_reg[i]   <= '0;
            end
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            serve_dir_reg <= serve_dir_next;
            launch_reg    <= launch_next;
            winner_reg    <= winner_next;
            for (int i = 0; i < 2; i++) begin
                score_reg[i] <= score_next[i];
                bcd_reg[i]   <= bcd_next[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        serve_dir_next = serve_dir_reg;
        launch_next    = 1'b0;
        winner_next    = winner_reg;
        score_next     = score_reg;
        bcd_next       = bcd_reg;

        case (state_reg)
            WAIT_SERVE: begin
                if (serve_req) begin
                    launch_next = 1'b1;
                    state_next  = PLAY;
                end
            end

            PLAY: begin
                if (goal_p1 && goal_p2) begin
                    // Ambiguous point: replay it without touching the score.
                    state_next = POINT_DELAY;
                    cnt_next   = '0;
                end else if (goal_p1) begin
                    score_next[0]  = score_inc[0];
                    bcd_next[0]    = bcd_inc[0];
                    serve_dir_next = 1'b0;
                    if (win_on_goal[0]) begin
                        state_next  = GAME_OVER;
                        winner_next = 2'b01;
                    end else begin
                        state_next = POINT_DELAY;
                        cnt_next   = '0;
                    end
                end else if (goal_p2) begin
                    score_next[1]  = score_inc[1];
                    bcd_next[1]    = bcd_inc[1];
                    serve_dir_next = 1'b1;
                    if (win_on_goal[1]) begin
                        state_next  = GAME_OVER;
                        winner_next = 2'b10;
                    end else begin
                        state_next = POINT_DELAY;
                        cnt_next   = '0;
                    end
                end
            end

            POINT_DELAY: begin
                if (DELAY_L == 10'd0) begin
                    state_next = WAIT_SERVE;
                end else if (frame_tick) begin
                    cnt_next = cnt_reg + 10'd1;
                    if ((cnt_reg + 10'd1) == DELAY_L) begin
                        state_next = WAIT_SERVE;
                    end
                end
            end

            GAME_OVER: begin
                // New match: clear everything but do not launch yet.
                if (serve_req) begin
                    for (int i = 0; i < 2; i++) begin
                        score_next[i] = '0;
                        bcd_next[i]   = '0;
                    end
                    winner_next    = 2'b00;
                    serve_dir_next = 1'b0;
                    state_next     = WAIT_SERVE;
                end
            end

            default: state_next = WAIT_SERVE;
        endcase
    end

    // Hold and game_over are decoded from the state register only, so they
    // stay free of any combinational path from the inputs.
    assign ball_hold   = (state_reg != PLAY);
    assign game_over   = (state_reg == GAME_OVER);
    assign ball_launch = launch_reg;
    assign serve_dir   = serve_dir_reg;
    assign winner      = winner_reg;
    assign p1_score    = score_reg[0];
    assign p2_score    = score_reg[1];
    assign p1_bcd      = bcd_reg[0];
    assign p2_bcd      = bcd_reg[1];

endmodule

// File: tb/tb_pong_score_keeper.sv
module tb_pong_score_keeper;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic       reset = 1'b1;
    logic       frame_tick = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0, serve_req = 1'b0;
    logic       ball_hold, ball_launch, serve_dir, game_over;
    logic [6:0] p1_score, p2_score;
    logic [7:0] p1_bcd, p2_bcd;
    logic [1:0] winner;

    // Second instance for the saturation run: WIN_SCORE=99, no pause.
    logic       goal_b = 1'b0, serve_b = 1'b0;
    logic       hold_b, launch_b, dir_b, go_b;
    logic [6:0] p1_b, p2_b;
    logic [7:0] bcd1_b, bcd2_b;
    logic [1:0] win_b;

    pong_score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .goal_p1(goal_p1), .goal_p2(goal_p2), .serve_req(serve_req),
        .ball_hold(ball_hold), .ball_launch(ball_launch), .serve_dir(serve_dir),
        .p1_score(p1_score), .p2_score(p2_score), .p1_bcd(p1_bcd), .p2_bcd(p2_bcd),
        .game_over(game_over), .winner(winner)
    );

    pong_score_keeper #(.WIN_SCORE(99), .SERVE_DELAY(0)) dut_sat (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .goal_p1(goal_b), .goal_p2(1'b0), .serve_req(serve_b),
        .ball_hold(hold_b), .ball_launch(launch_b), .serve_dir(dir_b),
        .p1_score(p1_b), .p2_score(p2_b), .p1_bcd(bcd1_b), .p2_bcd(bcd2_b),
        .game_over(go_b), .winner(win_b)
    );

    typedef struct {
        logic       g1, g2, sr, ft;
        logic [6:0] p1, p2;
        logic       hold, launch, dir, go;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    int exp_p1 = 0;
    int exp_p2 = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic g1, g2, sr, ft, input int p1, p2,
                       input logic hold, launch, dir, go, input logic [1:0] win);
        vec_t v;
        v.g1 = g1; v.g2 = g2; v.sr = sr; v.ft = ft;
        v.p1 = 7'(p1); v.p2 = 7'(p2);
        v.hold = hold; v.launch = launch; v.dir = dir; v.go = go; v.win = win;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs starting at a falling edge; outputs are
    // sampled at the following falling edge.
    task automatic cyc(input logic g1, g2, sr, ft);
        goal_p1 = g1; goal_p2 = g2; serve_req = sr; frame_tick = ft;
        @(negedge CLOCK_50);
        goal_p1 = 1'b0; goal_p2 = 1'b0; serve_req = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic check_all(input string tag, input int p1, p2, input logic hold, launch,
                             dir, go, input logic [1:0] win);
        chk({tag, ".p1_score"}, 32'(p1_score), 32'(p1));
        chk({tag, ".p2_score"}, 32'(p2_score), 32'(p2));
        chk({tag, ".p1_bcd"}, 32'(p1_bcd), 32'(to_bcd(p1)));
        chk({tag, ".p2_bcd"}, 32'(p2_bcd), 32'(to_bcd(p2)));
        chk({tag, ".ball_hold"}, 32'(ball_hold), 32'(hold));
        chk({tag, ".ball_launch"}, 32'(ball_launch), 32'(launch));
        chk({tag, ".serve_dir"}, 32'(serve_dir), 32'(dir));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
        chk({tag, ".winner"}, 32'(winner), 32'(win));
    endtask

    // Full point from WAIT_SERVE: serve, goal by 'who', then the 3-tick pause.
    task automatic point(input int who);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk($sformatf("pt%0d_%0d.launch", exp_p1, exp_p2), 32'(ball_launch), 32'd1);
        cyc(who == 1, who == 2, 1'b0, 1'b0);
        if (who == 1) exp_p1++; else exp_p2++;
        chk($sformatf("pt%0d_%0d.p1_bcd", exp_p1, exp_p2), 32'(p1_bcd), 32'(to_bcd(exp_p1)));
        chk($sformatf("pt%0d_%0d.p2_bcd", exp_p1, exp_p2), 32'(p2_bcd), 32'(to_bcd(exp_p2)));
        chk($sformatf("pt%0d_%0d.p1_score", exp_p1, exp_p2), 32'(p1_score), 32'(exp_p1));
        chk($sformatf("pt%0d_%0d.p2_score", exp_p1, exp_p2), 32'(p2_score), 32'(exp_p2));
        chk($sformatf("pt%0d_%0d.serve_dir", exp_p1, exp_p2), 32'(serve_dir), (who == 2) ? 32'd1 : 32'd0);
        $display("point by p%0d -> %0d-%0d bcd=%h/%h game_over=%0b", who, exp_p1, exp_p2,
                 p1_bcd, p2_bcd, game_over);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        //    g1 g2 sr ft  p1 p2 hold launch dir go win
        add(1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'b00); // goal ignored in WAIT_SERVE
        add(0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 2'b00); // first serve launches
        add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00); // launch is one cycle
        add(0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2'b00); // serve_req ignored in PLAY
        add(0, 1, 0, 0,  0, 1, 1, 0, 1, 0, 2'b00); // goal_p2 -> 0-1, dir 1
        add(0, 0, 1, 0,  0, 1, 1, 0, 1, 0, 2'b00); // no launch during pause
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00); // tick 1
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00); // tick 2
        add(1, 0, 0, 0,  0, 1, 1, 0, 1, 0, 2'b00); // goal ignored in pause
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00); // tick 3 -> WAIT_SERVE
        add(0, 0, 1, 0,  0, 1, 0, 1, 1, 0, 2'b00); // serve accepted
        add(1, 1, 0, 0,  0, 1, 1, 0, 1, 0, 2'b00); // simultaneous goals: replay
        add(0, 0, 1, 0,  0, 1, 1, 0, 1, 0, 2'b00); // still pausing
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00);
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00);
        add(0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 2'b00); // -> WAIT_SERVE
        add(0, 0, 1, 0,  0, 1, 0, 1, 1, 0, 2'b00);
        add(1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 2'b00); // goal_p1 -> 1-1, dir 0
        add(0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 2'b00);
        add(0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 2'b00);
        add(0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 2'b00); // -> WAIT_SERVE

        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        check_all("reset", 0, 0, 1, 0, 0, 0, 2'b00);
        $display("reset: hold=%0b launch=%0b scores=%0d-%0d", ball_hold, ball_launch, p1_score, p2_score);

        foreach (vecs[i]) begin
            cyc(vecs[i].g1, vecs[i].g2, vecs[i].sr, vecs[i].ft);
            check_all($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].hold,
                      vecs[i].launch, vecs[i].dir, vecs[i].go, vecs[i].win);
            $display("vec%0d in=%b%b%b%b p1=%0d p2=%0d hold=%0b launch=%0b dir=%0b", i,
                     vecs[i].g1, vecs[i].g2, vecs[i].sr, vecs[i].ft, p1_score, p2_score,
                     ball_hold, ball_launch, serve_dir);
        end
        exp_p1 = 1;
        exp_p2 = 1;

        // Up to 10-10; p1 crosses the 9 -> 10 BCD carry on the way.
        while (exp_p1 < 10) point(1);
        chk("bcd_carry.p1_bcd", 32'(p1_bcd), 32'h10);
        while (exp_p2 < 10) point(2);
        chk("ten_all.game_over", 32'(game_over), 32'd0);

        point(1); // 11-10
`ifdef PONG_WIN_BY_TWO_EN
        chk("win2_11_10.game_over", 32'(game_over), 32'd0);
        chk("win2_11_10.winner", 32'(winner), 32'd0);
        point(1); // 12-10
`endif
        chk("match_end.game_over", 32'(game_over), 32'd1);
        chk("match_end.winner", 32'(winner), 32'd1);
        chk("match_end.ball_hold", 32'(ball_hold), 32'd1);

        cyc(1'b0, 1'b0, 1'b1, 1'b0); // new match, no launch
        check_all("new_match", 0, 0, 1, 0, 0, 0, 2'b00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0); // second serve launches
        check_all("new_serve", 0, 0, 0, 1, 0, 0, 2'b00);
        $display("new match: launch=%0b hold=%0b", ball_launch, ball_hold);

        // Reset while in PLAY with a nonzero score.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_reset.p2_score", 32'(p2_score), 32'd1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_reset.launch", 32'(ball_launch), 32'd1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check_all("mid_reset", 0, 0, 1, 0, 0, 0, 2'b00);
        $display("mid-play reset: hold=%0b dir=%0b scores=%0d-%0d", ball_hold, serve_dir, p1_score, p2_score);

        // Saturation instance: 99 single points for player 1.
        for (int n = 1; n <= 99; n++) begin
            serve_b = 1'b1;
            @(negedge CLOCK_50);
            serve_b = 1'b0;
            goal_b  = 1'b1;
            @(negedge CLOCK_50);
            goal_b  = 1'b0;
            chk($sformatf("sat%0d.p1_bcd", n), 32'(bcd1_b), 32'(to_bcd(n)));
            if (n % 11 == 0 || n == 99)
                $display("sat point %0d: score=%0d bcd=%h", n, p1_b, bcd1_b);
            @(negedge CLOCK_50);
        end
        chk("sat.p1_score", 32'(p1_b), 32'd99);
        chk("sat.game_over", 32'(go_b), 32'd1);
        chk("sat.winner", 32'(win_b), 32'd1);
        goal_b = 1'b1;
        @(negedge CLOCK_50);
        goal_b = 1'b0;
        chk("sat_hold.p1_score", 32'(p1_b), 32'd99);
        chk("sat_hold.p1_bcd", 32'(bcd1_b), 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
